// File: rtl/param_fifo.sv
// Single-clock parameterised FIFO with flags.
// Supports registered-read and first-word-fall-through output modes.
module param_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 32,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = 28,
  parameter int AE_LEVEL  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_en,
  input  logic                   read_en,
  input  logic                   err_clr,
  input  logic [DATA_BITS-1:0]   data_in,
  output logic [DATA_BITS-1:0]   data_out,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;

  // Flags decode the registered count; gating uses pre-edge state
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
    push         = write_en & ~full;
    pop          = read_en & ~empty;
  end

  // Storage write; reset blocks a concurrent push, contents not cleared
  always_ff @(posedge clk) begin
    if (!reset && push)
      mem[wr_ptr] <= data_in;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event wins over err_clr
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full)
        overflow <= 1'b1;
      else if (err_clr)
        overflow <= 1'b0;
      if (read_en && empty)
        underflow <= 1'b1;
      else if (err_clr)
        underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == 0) begin : g_reg
      logic [DATA_BITS-1:0] dout_q;

      // Head word captured on the edge that accepts a pop
      always_ff @(posedge clk) begin
        if (reset)
          dout_q <= '0;
        else if (pop)
          dout_q <= mem[rd_ptr];
      end

      assign data_out = dout_q;
    end else begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo.
// Two instances (registered and FWFT) share one stimulus stream.
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en  = 1'b0;
  logic          err_clr  = 1'b0;
  logic [DW-1:0] data_in  = '0;

  logic [DW-1:0] d0_data_out, d1_data_out;
  logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
  logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
  logic [CW-1:0] d0_count, d1_count;

  param_fifo #(
    .DATA_BITS(DW), .DEPTH(DEPTH), .FWFT(0),
    .AF_LEVEL(28), .AE_LEVEL(4)
  ) dut0 (
    .clk(clk), .reset(reset),
    .write_en(write_en), .read_en(read_en),
    .err_clr(err_clr), .data_in(data_in),
    .data_out(d0_data_out), .full(d0_full),
    .empty(d0_empty), .almost_full(d0_af),
    .almost_empty(d0_ae), .count(d0_count),
    .overflow(d0_ovf), .underflow(d0_unf)
  );

  param_fifo #(
    .DATA_BITS(DW), .DEPTH(DEPTH), .FWFT(1),
    .AF_LEVEL(28), .AE_LEVEL(4)
  ) dut1 (
    .clk(clk), .reset(reset),
    .write_en(write_en), .read_en(read_en),
    .err_clr(err_clr), .data_in(data_in),
    .data_out(d1_data_out), .full(d1_full),
    .empty(d1_empty), .almost_full(d1_af),
    .almost_empty(d1_ae), .count(d1_count),
    .overflow(d1_ovf), .underflow(d1_unf)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  // Behavioural model: a queue of words plus sticky flags
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;
  bit            chk_en = 1'b0;

  always @(posedge clk) begin : model
    bit mf, me;
    if (reset) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      chk_en = 1'b1;
    end else begin
      mf = (q.size() == DEPTH);
      me = (q.size() == 0);
      if (write_en && mf) m_ovf = 1'b1;
      else if (err_clr)   m_ovf = 1'b0;
      if (read_en && me)  m_unf = 1'b1;
      else if (err_clr)   m_unf = 1'b0;
      if (read_en && !me) m_dout = q.pop_front();
      if (write_en && !mf) q.push_back(data_in);
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin : cmp
    int n;
    if (chk_en) begin
      n = q.size();
      check("count",    32'(d0_count), n);
      check("d1_count", 32'(d1_count), n);
      check("full",     32'(d0_full),  32'(n == DEPTH));
      check("d1_full",  32'(d1_full),  32'(n == DEPTH));
      check("empty",    32'(d0_empty), 32'(n == 0));
      check("d1_empty", 32'(d1_empty), 32'(n == 0));
      check("af",       32'(d0_af),    32'(n >= 28));
      check("ae",       32'(d0_ae),    32'(n <= 4));
      check("ovf",      32'(d0_ovf),   32'(m_ovf));
      check("d1_ovf",   32'(d1_ovf),   32'(m_ovf));
      check("unf",      32'(d0_unf),   32'(m_unf));
      check("d1_unf",   32'(d1_unf),   32'(m_unf));
      check("dout",     32'(d0_data_out), 32'(m_dout));
      if (n > 0)
        check("d1_dout", 32'(d1_data_out), 32'(q[0]));
    end
  end

  task automatic step(input bit we, input bit re,
                      input bit ec, input bit rst,
                      input logic [DW-1:0] d);
    @(negedge clk);
    write_en = we;
    read_en  = re;
    err_clr  = ec;
    reset    = rst;
    data_in  = d;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    err_clr  = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 1, 8'h00);
    check("rst_count", 32'(d0_count), 0);
    check("rst_empty", 32'(d0_empty), 1);
    check("rst_full",  32'(d0_full),  0);
    check("rst_ae",    32'(d0_ae),    1);
    check("rst_af",    32'(d0_af),    0);
    check("rst_dout",  32'(d0_data_out), 0);

    // Fill with 0x00..0x1F then drain in order
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 8'(i));
    check("fill_count", 32'(d0_count), 32);
    check("fill_full",  32'(d0_full),  1);
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 0, 8'h00);
      check("pop_data", 32'(d0_data_out), i);
    end
    check("drain_empty", 32'(d0_empty), 1);

    // Push+pop on a full FIFO: pop only, overflow set
    for (int i = 0; i < 32; i++)
      step(1, 0, 0, 0, 8'(8'h80 + i));
    step(1, 1, 0, 0, 8'hEE);
    check("full_rw_count", 32'(d0_count), 31);
    check("full_rw_ovf",   32'(d0_ovf),   1);
    check("full_rw_dout",  32'(d0_data_out), 32'h80);
    step(0, 0, 1, 0, 8'h00);
    check("ovf_clr", 32'(d0_ovf), 0);

    // Push+pop on an empty FIFO: push only, underflow set
    step(0, 0, 0, 1, 8'h00);
    step(1, 1, 0, 0, 8'h5A);
    check("empty_rw_count", 32'(d0_count), 1);
    check("empty_rw_unf",   32'(d0_unf),   1);
    step(0, 0, 1, 0, 8'h00);
    check("unf_clr", 32'(d0_unf), 0);
    step(0, 1, 0, 0, 8'h00);
    // err_clr with a new underflow in the same cycle: set wins
    step(0, 1, 1, 0, 8'h00);
    check("unf_set_wins", 32'(d0_unf), 1);

    // FWFT: word visible right after the push edge
    step(0, 0, 0, 1, 8'h00);
    step(1, 0, 0, 0, 8'hA5);
    check("fwft_dout",  32'(d1_data_out), 32'hA5);
    check("fwft_empty", 32'(d1_empty), 0);
    step(0, 1, 0, 0, 8'h00);
    check("fwft_pop_empty", 32'(d1_empty), 1);
    check("reg_pop_dout",   32'(d0_data_out), 32'hA5);

    // Thresholds
    step(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 27; i++)
      step(1, 0, 0, 0, 8'(i));
    check("af_27", 32'(d0_af), 0);
    step(1, 0, 0, 0, 8'd27);
    check("af_28",    32'(d0_af),    1);
    check("cnt_28",   32'(d0_count), 28);
    for (int i = 0; i < 23; i++)
      step(0, 1, 0, 0, 8'h00);
    check("ae_5", 32'(d0_ae), 0);
    step(0, 1, 0, 0, 8'h00);
    check("ae_4",  32'(d0_ae),    1);
    check("cnt_4", 32'(d0_count), 4);

    // Interleaved traffic to wrap the pointers
    for (int i = 0; i < 100; i++)
      step(i % 4 != 3, i % 4 != 0, 0, 0, 8'(8'h40 + i));
    while (q.size() > 0)
      step(0, 1, 0, 0, 8'h00);

    // Reset mid-operation with a concurrent push
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 0, 8'(8'hC0 + i));
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'hCA);
    check("pre_rst_count", 32'(d0_count), 10);
    step(1, 0, 0, 1, 8'h77);
    check("mid_rst_count", 32'(d0_count), 0);
    check("mid_rst_empty", 32'(d0_empty), 1);
    check("mid_rst_dout",  32'(d0_data_out), 0);
    step(0, 1, 0, 0, 8'h00);
    check("mid_rst_nopush", 32'(d0_count), 0);

    @(negedge clk);
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
